// File: rtl/riscv_dmem_store_buffer.sv
// Data-memory port for the MEM stage: posted store FIFO drained in order,
// blocking loads, and a load/store address hazard check on pending stores.
module riscv_dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_core_wr_en,
  input  logic            i_core_rd_en,
  input  logic [XLEN-1:0] i_core_addr,
  input  logic [XLEN-1:0] i_core_wr_data,
  input  logic [3:0]      i_core_byte_sel,
  output logic            o_core_stall,
  output logic [XLEN-1:0] o_core_rd_data,
  output logic            o_sb_empty,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic            o_mem_req_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic [3:0]      o_mem_byte_sel,
  input  logic            i_mem_rd_valid,
  input  logic [XLEN-1:0] i_mem_rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = XLEN - 2;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]   ent_tag  [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [3:0]      ent_sel  [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic full;
  logic push;
  logic pop;
  logic conflict;

  logic            valid_nxt;
  logic            we_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [3:0]      sel_nxt;
  logic [XLEN-1:0] rd_data_nxt;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_core_addr[1:0];

  assign full = (count == CW'(DEPTH));
  assign push = i_core_wr_en && (i_core_byte_sel != 4'h0) && !full;
  assign pop  = (state == WR_REQ) && i_mem_req_ready;

  assign o_sb_empty = (count == '0);

  // Empty-mask stores are dropped, so they never wait on a full FIFO
  assign o_core_stall =
    (i_core_wr_en && (i_core_byte_sel != 4'h0) && full) ||
    (i_core_rd_en && (state != RD_DONE));

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_tag[i] == i_core_addr[XLEN-1:2]))
        conflict = 1'b1;
    end
    conflict = conflict && i_core_rd_en;
  end

  always_comb begin
    state_nxt   = state;
    valid_nxt   = o_mem_req_valid;
    we_nxt      = o_mem_req_we;
    addr_nxt    = o_mem_addr;
    wdata_nxt   = o_mem_wr_data;
    sel_nxt     = o_mem_byte_sel;
    rd_data_nxt = o_core_rd_data;
    unique case (state)
      IDLE: begin
        if (i_core_rd_en && !conflict) begin
          state_nxt = RD_REQ;
          valid_nxt = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = {i_core_addr[XLEN-1:2], 2'b00};
          wdata_nxt = '0;
          sel_nxt   = 4'hF;
        end else if (count != '0) begin
          state_nxt = WR_REQ;
          valid_nxt = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = {ent_tag[rd_ptr], 2'b00};
          wdata_nxt = ent_data[rd_ptr];
          sel_nxt   = ent_sel[rd_ptr];
        end
      end
      WR_REQ: begin
        if (i_mem_req_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      RD_REQ: begin
        if (i_mem_req_ready) begin
          state_nxt = RD_WAIT;
          valid_nxt = 1'b0;
        end
      end
      RD_WAIT: begin
        if (i_mem_rd_valid) begin
          state_nxt   = RD_DONE;
          rd_data_nxt = i_mem_rd_data;
        end
      end
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      o_mem_req_valid <= 1'b0;
      o_mem_req_we    <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wr_data   <= '0;
      o_mem_byte_sel  <= 4'h0;
      o_core_rd_data  <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      ent_vld         <= '0;
    end else begin
      state           <= state_nxt;
      o_mem_req_valid <= valid_nxt;
      o_mem_req_we    <= we_nxt;
      o_mem_addr      <= addr_nxt;
      o_mem_wr_data   <= wdata_nxt;
      o_mem_byte_sel  <= sel_nxt;
      o_core_rd_data  <= rd_data_nxt;
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: the valid bits gate every use
  always_ff @(posedge i_clk) begin
    if (push) begin
      ent_tag[wr_ptr]  <= i_core_addr[XLEN-1:2];
      ent_data[wr_ptr] <= i_core_wr_data;
      ent_sel[wr_ptr]  <= i_core_byte_sel;
    end
  end

  a_no_wr_rd: assert property (
    @(posedge i_clk) disable iff (i_rst)
    !(i_core_wr_en && i_core_rd_en)
  );

endmodule

// File: doc/riscv_dmem_store_buffer.md
Name: riscv_dmem_store_buffer

Overview:
Data-memory interface between the pipelined core's MEM stage and a shared single-port memory bus with valid/ready request and valid-only read response. Stores are posted into a DEPTH-entry FIFO and drained in program order. Loads stall the core until read data returns. A load whose word address matches any pending store waits until that store has drained.

Parameters:
DEPTH, 4, store FIFO entries; power of two, >=2
XLEN, 32, data/address width (matches `XLEN)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_core_wr_en  in  1  MEM-stage store request
i_core_rd_en  in  1  MEM-stage load request; held stable by core while stalled
i_core_addr  in  XLEN  byte address
i_core_wr_data  in  XLEN  store data, already lane-aligned
i_core_byte_sel  in  4  store byte enables
o_core_stall  out  1  freeze pipeline (combinational)
o_core_rd_data  out  XLEN  full load word; valid when stall low for a load
o_sb_empty  out  1  FIFO empty and no store in flight
o_mem_req_valid  out  1  bus request valid (registered)
i_mem_req_ready  in  1  bus accepts request
o_mem_req_we  out  1  1=write, 0=read
o_mem_addr  out  XLEN  word-aligned address, [1:0]=0
o_mem_wr_data  out  XLEN  write data
o_mem_byte_sel  out  4  byte enables; 4'hF for reads
i_mem_rd_valid  in  1  read data valid, any cycle after read handshake
i_mem_rd_data  in  XLEN  read data

Behaviour:
- Reset (async, immediate): pointers/count=0, state IDLE, all entries invalid.
- Reset values: o_mem_req_valid=0, o_mem_req_we=0, o_mem_addr=0, o_mem_wr_data=0, o_mem_byte_sel=0, o_core_rd_data=0, o_sb_empty=1, o_core_stall=0.
- Reset mid-operation discards pending stores and any outstanding read. A later i_mem_rd_valid is ignored.
- FIFO entry: {addr[XLEN-1:2], data, byte_sel}. count width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Enqueue at clock edge when i_core_wr_en && count<DEPTH.
- Store with byte_sel==0: dropped, no stall.
- full = (count==DEPTH), from registered count. A pop in the same cycle does not clear full.
- o_core_stall = (i_core_wr_en && full) | (i_core_rd_en && state!=RD_DONE).
- conflict = i_core_rd_en && any valid entry (including the head in WR_REQ) has addr[XLEN-1:2]==i_core_addr[XLEN-1:2].
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE.
- IDLE:
  - if i_core_rd_en && !conflict -> RD_REQ (reads take priority over draining);
  - else if count>0 -> WR_REQ, loading the head entry into the bus regs;
  - else stay.
- WR_REQ: valid=1, we=1. On ready: pop head, valid=0 -> IDLE. Peak drain rate is one store per 2 cycles.
- RD_REQ: valid=1, we=0, byte_sel=F. On ready -> RD_WAIT, valid=0.
- RD_WAIT: on i_mem_rd_valid, capture o_core_rd_data -> RD_DONE.
- RD_DONE: stall released for one cycle, then -> IDLE. o_core_rd_data holds until the next capture.
- Bus outputs stay stable while valid && !ready. A started WR_REQ always completes before a read is issued.
- Minimum load latency (ready=1, rd_valid the cycle after handshake): stall high 3 cycles, low on the 4th.
- Stores cannot arrive while a load stalls the pipeline. Simultaneous wr_en and rd_en is illegal (assertion).
- o_sb_empty = (count==0).

Test Plan:
- Reset, store addr 0x100, data 0xDEADBEEF, sel F, ready=1 -> 2 cycles later bus shows we=1, addr 0x100, data 0xDEADBEEF, sel F for 1 cycle. o_sb_empty returns to 1.
- DEPTH=4, ready=0, 5 consecutive stores -> 5th stalls, count=4. Raise ready -> bus order is stores 1..5, 5th enqueued the cycle after first pop, no loss or duplication.
- Empty buffer, load 0x400, ready=1, rd_data 0x12345678 one cycle after handshake -> stall high exactly 3 cycles. o_core_rd_data=0x12345678 when stall drops.
- Pending store 0x204 sel 0011, ready=0. Load 0x206 -> no read issued while store pending. Raise ready -> bus sequence is write 0x204 then read 0x204.
- Pending stores 0x300 and 0x304, load 0x400, state IDLE -> read 0x400 issued before either store. Stores drain afterwards in order.
- Reset asserted during WR_REQ with ready=0 -> o_mem_req_valid=0 same cycle. o_sb_empty=1, no stale bus request after reset release.
